// File: rtl/signed_div_seq_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// latency and the controller state encoding.
package signed_div_seq_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS_A = 3'd1,
        ST_ABS_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX_Q = 3'd4,
        ST_FIX_R = 3'd5,
        ST_DONE  = 3'd6
    } div_state_e;

endpackage

// File: rtl/signed_div_seq_if.sv
// Request/response bundle between the control unit and the divider.
interface signed_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Requester side (control unit).
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/signed_div_seq_complement2s.sv
// Two's-complement negation unit (out = ~in + 1). Purely combinational;
// the divider owns the only instance and time-shares it between states.
module signed_div_seq_complement2s #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = ~in_i + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/signed_div_seq.sv
// Multi-cycle signed divider with truncating (C style) semantics.
// Operands are turned into magnitudes by a single shared negation unit,
// divided by a restoring shift-subtract loop, and the signs are applied
// back with the same unit. Latency is constant: every sign-fix state
// costs one cycle whether or not the value needs negating.
module signed_div_seq
    import signed_div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    signed_div_seq_if.slave   bus
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Controller state.
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Working datapath: a = dividend, b = divisor, q/r = quotient and
    // partial remainder of the shift-subtract loop.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    // Divide-by-zero result still to be published (first DONE cycle).
    logic             zero_pend_q, zero_pend_d;

    // Registered outputs.
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Shared negation unit and loop arithmetic.
    logic [WIDTH-1:0] neg_in_s;
    logic [WIDTH-1:0] neg_out_s;
    logic [WIDTH:0]   r_sh_s;
    logic [WIDTH:0]   trial_s;

    signed_div_seq_complement2s #(
        .WIDTH (WIDTH)
    ) u_neg (
        .in_i  (neg_in_s),
        .out_o (neg_out_s)
    );

    // Select which register feeds the negation unit in the current state.
    always_comb begin
        neg_in_s = {WIDTH{1'b0}};
        case (state_q)
            ST_ABS_A: neg_in_s = a_q;
            ST_ABS_B: neg_in_s = b_q;
            ST_FIX_Q: neg_in_s = q_q;
            ST_FIX_R: neg_in_s = r_q;
            default:  neg_in_s = {WIDTH{1'b0}};
        endcase
    end

    // Shift {R, Q} left by one and trial-subtract the divisor magnitude.
    // R stays below |divisor| <= 2^(WIDTH-1), so the WIDTH+1-bit result's
    // top bit is a reliable sign.
    assign r_sh_s  = {r_q, q_q[WIDTH-1]};
    assign trial_s = r_sh_s - {1'b0, b_q};

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ABS_A;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABS_A: state_d = ST_ABS_B;
            ST_ABS_B: state_d = ST_ITER;
            ST_ITER: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX_Q;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_FIX_Q: state_d = ST_FIX_R;
            ST_FIX_R: state_d = ST_DONE;
            ST_DONE: begin
                // A divide-by-zero spends one silent DONE cycle before the
                // pulse so its done lands two edges after acceptance.
                if (zero_pend_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next-values for each state.
    always_comb begin
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        q_d         = q_q;
        r_d         = r_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        zero_pend_d = zero_pend_q;
        done_d      = 1'b0;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;
        busy_d      = state_d inside {ST_ABS_A, ST_ABS_B, ST_ITER, ST_FIX_Q, ST_FIX_R};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d         = bus.dividend;
                    b_d         = bus.divisor;
                    neg_quo_d   = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_rem_d   = bus.dividend[WIDTH-1];
                    zero_pend_d = (bus.divisor == {WIDTH{1'b0}});
                    cnt_d       = {CNT_W{1'b0}};
                    quo_d       = {WIDTH{1'b0}};
                    rem_d       = {WIDTH{1'b0}};
                    dbz_d       = 1'b0;
                end else begin
                    a_d = a_q;
                end
            end
            ST_ABS_A: begin
                if (neg_rem_q) begin
                    a_d = neg_out_s;
                end else begin
                    a_d = a_q;
                end
            end
            ST_ABS_B: begin
                if (b_q[WIDTH-1]) begin
                    b_d = neg_out_s;
                end else begin
                    b_d = b_q;
                end
                q_d = a_q;
                r_d = {WIDTH{1'b0}};
            end
            ST_ITER: begin
                if (!trial_s[WIDTH]) begin
                    r_d = trial_s[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_sh_s[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX_Q: begin
                if (neg_quo_q) begin
                    q_d = neg_out_s;
                end else begin
                    q_d = q_q;
                end
            end
            ST_FIX_R: begin
                quo_d = q_q;
                if (neg_rem_q) begin
                    rem_d = neg_out_s;
                end else begin
                    rem_d = r_q;
                end
                dbz_d  = 1'b0;
                done_d = 1'b1;
            end
            ST_DONE: begin
                if (zero_pend_q) begin
                    quo_d       = {WIDTH{1'b1}};
                    rem_d       = a_q;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    zero_pend_d = 1'b0;
                end else begin
                    zero_pend_d = 1'b0;
                end
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            q_q         <= {WIDTH{1'b0}};
            r_q         <= {WIDTH{1'b0}};
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quo_q       <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            q_q         <= q_d;
            r_q         <= r_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            zero_pend_q <= zero_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_div_seq.sv
// Self-checking bench for signed_div_seq: directed corner cases, ignored
// start pulses, mid-operation reset and randomized operands against a
// plain-arithmetic reference model.
module tb_signed_div_seq;
    import signed_div_seq_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] op_a;
    logic [31:0] op_b;

    signed_div_seq_if #(.WIDTH(W)) dif ();

    signed_div_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truncating signed division computed with 64-bit arithmetic.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          edges;
        int          busy_n;
        bit          got;
        ref_div(a, b, eq, er, ez);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        edges  = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && edges < DIV_LATENCY + 8) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            dif.start = 1'b0;
            if (edges == 1) begin
                check_val({tag, ":clr_q"}, 64'(dif.quotient), 64'd0);
                check_val({tag, ":clr_r"}, 64'(dif.remainder), 64'd0);
            end
            if (dif.busy) busy_n++;
            if (dif.done) got = 1'b1;
        end
        check_val({tag, ":done_seen"}, 64'(got), 64'd1);
        check_val({tag, ":edges"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'(W + 5));
        check_val({tag, ":busy_cycles"}, 64'(busy_n), (b == 32'd0) ? 64'd0 : 64'(W + 4));
        check_val({tag, ":quot"}, 64'(dif.quotient), 64'(eq));
        check_val({tag, ":rem"}, 64'(dif.remainder), 64'(er));
        check_val({tag, ":dbz"}, 64'(dif.div_by_zero), 64'(ez));
        check_val({tag, ":busy_at_done"}, 64'(dif.busy), 64'd0);
        @(negedge clk);
        check_val({tag, ":done_one_cycle"}, 64'(dif.done), 64'd0);
        check_val({tag, ":quot_held"}, 64'(dif.quotient), 64'(eq));
        check_val({tag, ":rem_held"}, 64'(dif.remainder), 64'(er));
    endtask

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          edges;
        int          dones;
        int          done_edge;
        int          sel;

        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = 32'd0;
        dif.divisor  = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(dif.busy), 64'd0);
        check_val("rst_done", 64'(dif.done), 64'd0);
        check_val("rst_quot", 64'(dif.quotient), 64'd0);
        check_val("rst_rem", 64'(dif.remainder), 64'd0);
        check_val("rst_dbz", 64'(dif.div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_op(32'd100, 32'd7, "p100_p7");
        check_val("p100_p7:q_const", 64'(dif.quotient), 64'd14);
        check_val("p100_p7:r_const", 64'(dif.remainder), 64'd2);
        do_op(-32'sd100, 32'd7, "m100_p7");
        check_val("m100_p7:q_const", 64'(dif.quotient), 64'hFFFF_FFF2);
        check_val("m100_p7:r_const", 64'(dif.remainder), 64'hFFFF_FFFE);
        do_op(32'd100, -32'sd7, "p100_m7");
        check_val("p100_m7:r_const", 64'(dif.remainder), 64'd2);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, "min_m1");
        check_val("min_m1:q_const", 64'(dif.quotient), 64'h8000_0000);
        do_op(32'h8000_0000, 32'd1, "min_p1");
        do_op(32'd1234, 32'd0, "div0");
        check_val("div0:r_const", 64'(dif.remainder), 64'd1234);

        // Extra start pulses while busy and during DONE must be ignored.
        ref_div(32'd50, 32'd3, eq, er, ez);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd50;
        dif.divisor  = 32'd3;
        edges     = 0;
        dones     = 0;
        done_edge = 0;
        while (edges < 45) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 6 || edges == 37) begin
                dif.start    = 1'b1;
                dif.dividend = 32'd9;
                dif.divisor  = 32'd9;
            end else begin
                dif.start = 1'b0;
            end
            if (dif.done) begin
                dones++;
                done_edge = edges;
                check_val("ign:busy_at_done", 64'(dif.busy), 64'd0);
            end
        end
        check_val("ign:done_count", 64'(dones), 64'd1);
        check_val("ign:done_edge", 64'(done_edge), 64'd37);
        check_val("ign:quot", 64'(dif.quotient), 64'(eq));
        check_val("ign:rem", 64'(dif.remainder), 64'(er));
        check_val("ign:busy_after", 64'(dif.busy), 64'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd1000;
        dif.divisor  = 32'd10;
        for (int e = 1; e <= 21; e++) begin
            @(posedge clk);
            @(negedge clk);
            dif.start = 1'b0;
        end
        check_val("mrst:busy_before", 64'(dif.busy), 64'd1);
        rst = 1'b1;
        #1;
        check_val("mrst:busy", 64'(dif.busy), 64'd0);
        check_val("mrst:done", 64'(dif.done), 64'd0);
        check_val("mrst:quot", 64'(dif.quotient), 64'd0);
        check_val("mrst:rem", 64'(dif.remainder), 64'd0);
        check_val("mrst:dbz", 64'(dif.div_by_zero), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int e = 0; e < 45; e++) begin
            @(negedge clk);
            if (dif.done) dones++;
        end
        check_val("mrst:no_done", 64'(dones), 64'd0);
        do_op(32'd7, 32'd2, "post_rst");
        check_val("post_rst:q_const", 64'(dif.quotient), 64'd3);
        check_val("post_rst:r_const", 64'(dif.remainder), 64'd1);

        // Randomized operands.
        for (int i = 0; i < 40; i++) begin
            op_a = $urandom;
            sel  = $urandom_range(0, 7);
            case (sel)
                0: op_b = 32'd0;
                1: op_b = 32'($urandom_range(1, 15));
                2: op_b = -(32'($urandom_range(1, 15)));
                3: begin
                    op_a = 32'h8000_0000;
                    op_b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
                end
                4: begin
                    op_a = 32'($urandom_range(0, 1000));
                    op_b = $urandom;
                end
                default: op_b = $urandom;
            endcase
            do_op(op_a, op_b, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_div_seq.md
# signed_div_seq

Multi-cycle 32-bit signed integer divider for the lab CPU's ALU/MDU path. It sequences one shared two's-complement negation unit (the existing `Complement2s` block, `out = ~in + 1`) together with a restoring shift-subtract core. The negation unit converts operands to magnitudes and applies signs to the results. The block sits beside the ALU and is started by the control unit for DIV-class instructions; the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width. The latency formula holds for any value; only 32 is verified.
- `clk` in, 1: rising-edge clock.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: request; sampled only in IDLE.
- `dividend` in, WIDTH: signed dividend, captured on accepted `start`.
- `divisor` in, WIDTH: signed divisor, captured on accepted `start`.
- `busy` out, 1: high from the edge after acceptance until `done` is raised.
- `done` out, 1: one-cycle pulse; results are valid from this cycle onward.
- `quotient` out, WIDTH: signed quotient, held until the next accepted `start`.
- `remainder` out, WIDTH: signed remainder, held likewise.
- `div_by_zero` out, 1: set with `done` when divisor == 0; held with the results.

## Operation
- Semantics: truncating division (C style).
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign = sign(dividend).
  - Invariant: dividend == quotient*divisor + remainder.
- States and transitions:
  - IDLE -> ABS_A on `start` with divisor != 0.
  - IDLE -> DONE on `start` with divisor == 0.
  - ABS_A -> ABS_B -> ITER (WIDTH cycles) -> FIX_Q -> FIX_R -> DONE -> IDLE.
- Negation unit: exactly one instance, input selected by state.
  - ABS_A: dividend register.
  - ABS_B: divisor register.
  - FIX_Q: quotient register.
  - FIX_R: remainder register.
  - Each of these states writes back the negated value only if the relevant sign is set; otherwise it holds. The cycle is spent regardless, so latency is constant.
- ITER step, WIDTH+1-bit partial remainder R:
  - Shift {R, Q} left by 1.
  - Compute trial = R − |divisor|.
  - If trial ≥ 0: R = trial and Q[0] = 1.
  - An iteration counter runs 0..WIDTH−1; the state exits when the count equals WIDTH−1.
- Magnitudes are treated as unsigned. |−2^31| = 0x80000000 is therefore correct without a special case.
- Overflow: −2^31 / −1 gives quotient 0x80000000, remainder 0, and no flag (wraps, matching the ISA spec).
- Divide by zero: quotient = all ones, remainder = dividend, `div_by_zero` = 1.
- `start` outside IDLE is ignored. Operands are not re-captured.
- `start` in the DONE cycle is ignored; it is accepted the following cycle in IDLE.

## Timing
- Reset values: state IDLE; `busy` 0, `done` 0, `quotient` 0, `remainder` 0, `div_by_zero` 0; counter 0.
- Normal latency: with `start` sampled at edge k, `done` is high in the cycle after edge k+WIDTH+4 (k+36 for WIDTH = 32).
  - Busy cycles: ABS_A, ABS_B, ITER ×WIDTH, FIX_Q, FIX_R.
  - `busy` is high for WIDTH+4 cycles, then falls in the same edge that raises `done`.
- Divide-by-zero latency: `done` is high in the cycle after edge k+1. `busy` never rises.
- `done` lasts exactly one cycle. Outputs are stable from `done` until the edge that accepts the next `start`.
  - On that edge, `quotient`, `remainder` and `div_by_zero` are cleared to 0.
- Reset mid-operation: all outputs return immediately (asynchronously) to their reset values, and no `done` is issued. The first `start` after `rst` deasserts is accepted normally.
- Back-to-back use: minimum issue interval is WIDTH+6 cycles (start, busy span, DONE, IDLE).

## Structure
- Shared header `div_defs.vh`: state encodings (IDLE, ABS_A, ABS_B, ITER, FIX_Q, FIX_R, DONE; 3-bit), `DIV_WIDTH` = 32, `DIV_LATENCY` = DIV_WIDTH+4.
- One sub-module: the existing `Complement2s` negation unit, instantiated once and fed by the state-selected mux. No other negation logic is allowed in the block.
- The ITER subtractor is local: a WIDTH+1-bit subtract.

## Test plan
- 100 / 7 -> `done` after 37 edges; quotient 14, remainder 2, `div_by_zero` 0.
- −100 / 7 -> quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2). 100 / −7 -> quotient −14, remainder 2.
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. 0x80000000 / 1 -> quotient 0x80000000, remainder 0.
- 1234 / 0 -> `done` 2 edges after `start`; quotient 0xFFFFFFFF, remainder 1234, `div_by_zero` 1, `busy` never high.
- Stimulus: start 50/3, then pulse `start` with 9/9 at cycles 5 and 36 (DONE). Required response: both extra starts ignored; result 16 r 2; `busy` low from the DONE cycle.
- Stimulus: start 1000/10, assert `rst` at cycle 20, release, then start 7/2. Required response: immediate clear of all outputs, no `done` for the first operation; then quotient 3, remainder 1 after 37 edges.
